spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//   SPI master sequencer for the 4-slave SPI bus. Takes one-shot transfer requests
//   (slave index + DATA_W-bit word) and drives SCLK, MOSI and the 4-bit slave select
//   code. It shifts in MISO from the downstream MISO decoder mux and returns the
//   received word. Mode 0 only (CPOL=0, CPHA=0), MSB first, one transfer at a time.
// PARAMETERS
//   DATA_W   8  bits per transfer (>=2)
//   CLK_DIV  2  system clocks per SCLK half-period (>=1); SCLK = f_clk/(2*CLK_DIV)
// PORTS
//   clk        in   1       system clock, all logic on rising edge
//   rst        in   1       asynchronous reset, active-high
//   start      in   1       transfer request; accepted only when busy=0
//   slave_sel  in   2       target slave index 0..3, captured at accept
//   tx_data    in   DATA_W  word to send, captured at accept
//   busy       out  1       1 from the cycle after accept until the done cycle (exclusive)
//   done       out  1       1-cycle pulse; rx_data is valid in that cycle and held after
//   rx_data    out  DATA_W  last received word
//   cs_code    out  4       slave select code to the bus and to the MISO decoder
//   sclk       out  1       SPI clock
//   mosi       out  1       SPI data out
//   miso       in   1       decoded MISO; reads 1 when cs_code is idle
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, cs_code=4'b1111, sclk=0, mosi=0, busy=0,
//     done=0, rx_data=0, counters=0. Reset mid-transfer aborts it with no done pulse.
//   cs_code map: sel0=4'b0011 sel1=4'b1101 sel2=4'b1011 sel3=4'b0111 idle=4'b1111.
//   FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//   IDLE: cs_code=1111, sclk=0. If start=1, capture sel/tx in that cycle. Next cycle
//     the FSM is in SETUP with busy=1, cs_code=map(sel), and mosi=tx[DATA_W-1].
//   SETUP: lasts CLK_DIV cycles with sclk=0. On expiry go to XFER and drive sclk=1
//     (first rising edge).
//   XFER: 2*DATA_W half-periods of CLK_DIV cycles each. A half-period counter counts
//     0..CLK_DIV-1 and sclk toggles on wrap.
//     Rising toggle: shift miso into rx shift register (LSB in).
//     Falling toggle: drive the next tx bit on mosi. After the last bit's falling
//     toggle, go to HOLD with sclk=0.
//   HOLD: CLK_DIV cycles with sclk=0 and cs_code still asserted. On expiry go to
//     IDLE with cs_code=1111. In that same cycle done=1, busy=0 and
//     rx_data=shift register.
//   Latency: done is asserted exactly 1+CLK_DIV*(2*DATA_W+2) cycles after the accept
//     cycle.
//   start while busy=1: ignored, not queued.
//   start in the done cycle: accepted (back-to-back). cs_code is 1111 for exactly
//     1 cycle between the two transfers.
//   slave_sel/tx_data changes after accept have no effect on the running transfer.
//   mosi holds its last bit in IDLE. sclk is low in IDLE, SETUP and HOLD.
// STRUCTURE
//   Shared package (spi_pkg): CS_CODE_S0..S3, CS_CODE_IDLE, the state encoding
//     typedef/localparams, the sel->code function. The MISO decoder uses the same
//     constants.
//   Sub-module: spi_clk_gen (half-period counter + sclk toggle, emits rise/fall
//     strobes). The rest is a single always_ff FSM with shift registers.
// TESTING (DATA_W=8, CLK_DIV=2 unless noted)
//   1. start, sel=2, tx=0xA5; slave model returns 0x3C. cs_code=1011 throughout;
//      mosi on rising edges is 1,0,1,0,0,1,0,1; done at accept+37; rx_data=0x3C.
//   2. sel=0..3 in sequence, tx=0xFF. cs_code is 0011/1101/1011/0111 in turn and
//      1111 between transfers; with MISO idle, rx_data=0xFF.
//   3. Pulse start again while busy, with sel=1. Ignored: cs_code unchanged, a
//      single done pulse.
//   4. Raise start in the done cycle. Next transfer accepted; 1111 lasts exactly
//      one cycle; both rx_data values are correct.
//   5. Assert rst during bit 4 of XFER. Immediately cs_code=1111, sclk=0, busy=0,
//      no done. A new transfer after reset completes normally.
//   6. CLK_DIV=1, tx=0x81, loopback mosi->miso. SCLK is f_clk/2; done at accept+19;
//      rx_data=0x81.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Constants and helpers that the SPI master sequencer and the MISO decoder
//   share: the slave-select codes, the sequencer state encoding and the
//   slave-index to select-code mapping.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam logic [3:0] CS_CODE_S0   = 4'b0011;
    localparam logic [3:0] CS_CODE_S1   = 4'b1101;
    localparam logic [3:0] CS_CODE_S2   = 4'b1011;
    localparam logic [3:0] CS_CODE_S3   = 4'b0111;
    localparam logic [3:0] CS_CODE_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // Slave index to bus select code.
    function automatic logic [3:0] sel_to_cs(input logic [1:0] sel);
        logic [3:0] code;
        unique case (sel)
            2'd0:    code = CS_CODE_S0;
            2'd1:    code = CS_CODE_S1;
            2'd2:    code = CS_CODE_S2;
            default: code = CS_CODE_S3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
//   Half-period timer and SCLK generator. While en is high, a counter runs
//   0..CLK_DIV-1 and pulses wrap on its last count. If toggle_en is also high
//   at a wrap, SCLK toggles and the matching rise/fall strobe pulses in the
//   same cycle (the strobes describe the edge that the next clock produces).
//   With en low the counter is cleared and SCLK is held low.
// Ports
//   clk, rst   system clock, asynchronous active-high reset
//   en         run the half-period counter
//   toggle_en  allow SCLK to toggle at the next wrap
//   sclk       SPI clock (registered)
//   wrap       half-period boundary strobe
//   rise       SCLK goes 0->1 at this clock edge
//   fall       SCLK goes 1->0 at this clock edge
// ---------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    output logic sclk,
    output logic wrap,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign wrap = en && (cnt == CNT_LAST);
    assign rise = wrap && toggle_en && !sclk;
    assign fall = wrap && toggle_en &&  sclk;

    // NOTE: every register here is sequential state, so it is written with
    // non-blocking assignments only and cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (rise || fall) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//   SPI master sequencer for the 4-slave bus, mode 0 (CPOL=0, CPHA=0), MSB
//   first, one transfer at a time. A start pulse in IDLE captures the slave
//   index and tx word; the sequencer then runs SETUP -> XFER -> HOLD and
//   returns to IDLE with a one-cycle done pulse and the received word.
// Parameters
//   DATA_W   bits per transfer (>=2)
//   CLK_DIV  system clocks per SCLK half-period (>=1)
// Ports
//   clk, rst   system clock, asynchronous active-high reset
//   start      transfer request, accepted in IDLE only
//   slave_sel  target slave index, captured at accept
//   tx_data    word to send, captured at accept
//   busy       high while a transfer is running (not in the done cycle)
//   done       one-cycle pulse, rx_data valid from this cycle on
//   rx_data    last received word
//   cs_code    slave select code to the bus and the MISO decoder
//   sclk       SPI clock
//   mosi       SPI data out
//   miso       decoded SPI data in
// ---------------------------------------------------------------------------
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        slave_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic [3:0]        cs_code,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    // Half-periods in XFER: DATA_W high phases interleaved with DATA_W low
    // phases, starting high. The last one is low and ends without a toggle.
    localparam int HP_W = $clog2(2 * DATA_W);
    localparam logic [HP_W-1:0] HP_LAST      = HP_W'(2 * DATA_W - 1);
    localparam logic [HP_W-1:0] HP_LAST_FALL = HP_W'(2 * DATA_W - 2);

    spi_state_t        state;
    logic [HP_W-1:0]   hp_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;

    logic clk_en;
    logic toggle_en;
    logic wrap;
    logic rise;
    logic fall;

    assign clk_en    = (state != ST_IDLE);
    // The SETUP expiry produces the first rising edge; in XFER every boundary
    // toggles except the final one, which leaves SCLK low for HOLD.
    assign toggle_en = (state == ST_SETUP) ||
                       ((state == ST_XFER) && (hp_cnt != HP_LAST));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (clk_en),
        .toggle_en (toggle_en),
        .sclk      (sclk),
        .wrap      (wrap),
        .rise      (rise),
        .fall      (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hp_cnt   <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            cs_code  <= CS_CODE_IDLE;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SETUP;
                        busy     <= 1'b1;
                        cs_code  <= sel_to_cs(slave_sel);
                        mosi     <= tx_data[DATA_W-1];
                        // MSB is already on the wire; keep the rest left-aligned.
                        tx_shift <= tx_data << 1;
                        hp_cnt   <= '0;
                    end
                end

                ST_SETUP: begin
                    if (rise) begin
                        state    <= ST_XFER;
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                    end
                end

                ST_XFER: begin
                    if (wrap) begin
                        if (hp_cnt == HP_LAST) begin
                            state <= ST_HOLD;
                        end else begin
                            hp_cnt <= hp_cnt + 1'b1;
                        end
                    end
                    if (rise) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                    end
                    // The final falling edge has no further bit, so mosi keeps
                    // the LSB through HOLD and IDLE.
                    if (fall && (hp_cnt != HP_LAST_FALL)) begin
                        mosi     <= tx_shift[DATA_W-1];
                        tx_shift <= tx_shift << 1;
                    end
                end

                ST_HOLD: begin
                    if (wrap) begin
                        state   <= ST_IDLE;
                        cs_code <= CS_CODE_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_shift;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Directed bench for spi_master_ctrl. dut drives a mode-0 slave model
//   (DATA_W=8, CLK_DIV=2); dut2 runs with CLK_DIV=1 and MOSI looped to MISO.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start;
    logic [1:0] slave_sel;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic [3:0] cs_code;
    logic       sclk;
    logic       mosi;
    logic       miso;

    logic       start2;
    logic [1:0] slave_sel2;
    logic [7:0] tx_data2;
    logic       busy2;
    logic       done2;
    logic [7:0] rx_data2;
    logic [3:0] cs_code2;
    logic       sclk2;
    logic       mosi2;

    int n_err    = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .slave_sel (slave_sel),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .cs_code   (cs_code),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso)
    );

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(1)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .slave_sel (slave_sel2),
        .tx_data   (tx_data2),
        .busy      (busy2),
        .done      (done2),
        .rx_data   (rx_data2),
        .cs_code   (cs_code2),
        .sclk      (sclk2),
        .mosi      (mosi2),
        .miso      (mosi2)
    );

    // Mode-0 slave: presents slave_word MSB first, advancing on each falling
    // SCLK while selected; the decoder returns 1 when nothing is selected.
    logic [7:0] slave_word = 8'hFF;
    int         nfall      = 0;
    logic       cs_act;
    assign cs_act = (cs_code != 4'b1111);

    always @(negedge sclk or negedge cs_act) begin
        if (!cs_act) nfall <= 0;
        else         nfall <= nfall + 1;
    end

    assign miso = !cs_act ? 1'b1 :
                  (nfall < 8) ? slave_word[3'(7 - nfall)] : 1'b1;

    // Observers: mosi at each rising SCLK, select-code consistency, pulses.
    logic [7:0] mosi_cap = 8'h00;
    int         rise_cnt = 0;
    logic [3:0] exp_cs   = 4'b1111;
    int         cs_bad   = 0;
    int         done_cnt = 0;
    int         hi2_cnt  = 0;
    int         rise2    = 0;

    always @(posedge sclk) begin
        mosi_cap <= {mosi_cap[6:0], mosi};
        rise_cnt <= rise_cnt + 1;
    end

    always @(posedge sclk2) rise2 <= rise2 + 1;

    always @(negedge clk) begin
        if (busy && (cs_code !== exp_cs)) cs_bad <= cs_bad + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (busy2 && sclk2) hi2_cnt <= hi2_cnt + 1;
    end

    logic [3:0] cs_tab [4] = '{4'b0011, 4'b1101, 4'b1011, 4'b0111};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the inputs to show they
    // are no longer used. Returns at the negedge after the accept edge.
    task automatic launch(input logic [1:0] s, input logic [7:0] d);
        slave_sel = s;
        tx_data   = d;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        slave_sel = ~s;
        tx_data   = ~d;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int r0;
    int d0;
    int b0;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        slave_sel  = 2'd0;
        tx_data    = 8'h00;
        start2     = 1'b0;
        slave_sel2 = 2'd0;
        tx_data2   = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs",   32'(cs_code), 32'h F);
        check("rst_sclk", 32'(sclk),    32'h0);
        check("rst_mosi", 32'(mosi),    32'h0);
        check("rst_busy", 32'(busy),    32'h0);
        check("rst_done", 32'(done),    32'h0);
        check("rst_rx",   32'(rx_data), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1 + 3: sel=2, tx=A5, slave returns 3C; a start pulse while busy is ignored
        slave_word = 8'h3C;
        exp_cs     = 4'b1011;
        r0 = rise_cnt; d0 = done_cnt; b0 = cs_bad;
        launch(2'd2, 8'hA5);
        lat = 1;
        check("t1_busy",  32'(busy),    32'h1);
        check("t1_cs",    32'(cs_code), 32'hB);
        check("t1_mosi0", 32'(mosi),    32'h1);
        repeat (9) begin @(negedge clk); lat++; end
        slave_sel = 2'd1;
        tx_data   = 8'h00;
        start     = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        check("t3_cs_unchanged", 32'(cs_code), 32'hB);
        wait_done(lat);
        check("t1_latency", 32'(lat),     32'd37);
        check("t1_rx",      32'(rx_data), 32'h3C);
        check("t1_busy_dn", 32'(busy),    32'h0);
        check("t1_cs_idle", 32'(cs_code), 32'hF);
        check("t1_mosi_seq", 32'(mosi_cap), 32'hA5);
        check("t1_rises",   32'(rise_cnt - r0), 32'd8);
        check("t1_mosi_hold", 32'(mosi), 32'h1);
        repeat (3) @(negedge clk);
        check("t3_one_done", 32'(done_cnt - d0), 32'd1);
        check("t1_cs_bad",   32'(cs_bad - b0),   32'd0);
        check("t1_rx_held",  32'(rx_data),       32'h3C);

        // 2: each slave in turn, MISO idle-high
        for (int s = 0; s < 4; s++) begin
            slave_word = 8'hFF;
            exp_cs     = cs_tab[s];
            b0         = cs_bad;
            launch(2'(s), 8'hFF);
            lat = 1;
            check($sformatf("t2_cs%0d", s), 32'(cs_code), 32'(cs_tab[s]));
            wait_done(lat);
            check($sformatf("t2_lat%0d", s), 32'(lat), 32'd37);
            check($sformatf("t2_rx%0d", s), 32'(rx_data), 32'hFF);
            check($sformatf("t2_idle%0d", s), 32'(cs_code), 32'hF);
            check($sformatf("t2_csbad%0d", s), 32'(cs_bad - b0), 32'd0);
            @(negedge clk);
        end

        // 4: back-to-back, second start raised in the done cycle
        slave_word = 8'h96;
        exp_cs     = 4'b0111;
        b0         = cs_bad;
        launch(2'd3, 8'h5A);
        lat = 1;
        wait_done(lat);
        check("t4_lat_a",  32'(lat),     32'd37);
        check("t4_rx_a",   32'(rx_data), 32'h96);
        check("t4_gap_cs", 32'(cs_code), 32'hF);
        slave_word = 8'hC3;
        exp_cs     = 4'b0011;
        launch(2'd0, 8'h33);
        lat = 1;
        check("t4_cs_b",   32'(cs_code), 32'h3);
        check("t4_busy_b", 32'(busy),    32'h1);
        wait_done(lat);
        check("t4_lat_b",  32'(lat),     32'd37);
        check("t4_rx_b",   32'(rx_data), 32'hC3);
        check("t4_mosi_b", 32'(mosi_cap), 32'h33);
        check("t4_csbad",  32'(cs_bad - b0), 32'd0);
        @(negedge clk);

        // 5: reset during bit 4 of XFER, then a clean transfer
        slave_word = 8'h0F;
        exp_cs     = 4'b1101;
        launch(2'd1, 8'hF0);
        lat = 1;
        repeat (18) begin @(negedge clk); lat++; end
        check("t5_pre_busy", 32'(busy), 32'h1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("t5_rst_cs",   32'(cs_code), 32'hF);
        check("t5_rst_sclk", 32'(sclk),    32'h0);
        check("t5_rst_busy", 32'(busy),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        slave_word = 8'hA5;
        exp_cs     = 4'b0011;
        b0         = cs_bad;
        launch(2'd0, 8'h3C);
        lat = 1;
        wait_done(lat);
        check("t5_lat", 32'(lat),     32'd37);
        check("t5_rx",  32'(rx_data), 32'hA5);
        check("t5_csbad", 32'(cs_bad - b0), 32'd0);
        @(negedge clk);

        // 6: CLK_DIV=1 loopback
        r0 = rise2;
        b0 = hi2_cnt;
        slave_sel2 = 2'd2;
        tx_data2   = 8'h81;
        start2     = 1'b1;
        @(negedge clk);
        start2   = 1'b0;
        tx_data2 = 8'h00;
        lat = 1;
        check("t6_cs", 32'(cs_code2), 32'hB);
        while (!done2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("t6_lat",    32'(lat),          32'd19);
        check("t6_rx",     32'(rx_data2),     32'h81);
        check("t6_rises",  32'(rise2 - r0),   32'd8);
        check("t6_hi_cyc", 32'(hi2_cnt - b0), 32'd8);
        check("t6_idle",   32'(cs_code2),     32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
